fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 16, program counter width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, bubble cycles after a taken branch; legal range 1..15.
REQ-004 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-005 SHALL have ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: stall_i in 1, RAW-hazard hold request; branch_taken_i in 1, execute-stage redirect; branch_target_i in PC_W, redirect address.
REQ-007 SHALL have ports: imem_addr out PC_W, combinational instruction-memory address; imem_data in INSTR_W, combinational read data for imem_addr.
REQ-008 SHALL have ports: instr_d out INSTR_W, IF/ID instruction; pc_d out PC_W, IF/ID PC; valid_d out 1, IF/ID valid.
REQ-009 SHALL have ports: bubble_e out 1, insert NOP into execute this cycle; flush_busy out 1, FLUSH state active; resume_o out 1, one-cycle pulse on FLUSH exit; stall_cycles out 16, hazard-stall counter.

Function
REQ-010 SHALL hold internal pc register; imem_addr SHALL equal pc at all times.
REQ-011 SHALL implement two states, RUN and FLUSH, plus 4-bit flush counter fcnt.
REQ-012 In RUN with branch_taken_i=1, SHALL at the edge: pc<=branch_target_i, valid_d<=0, fcnt<=FLUSH_CYCLES-1, state<=FLUSH; branch_taken_i SHALL take priority over stall_i.
REQ-013 In RUN with branch_taken_i=0 and stall_i=1, SHALL hold pc, instr_d, pc_d, valid_d unchanged.
REQ-014 In RUN with both inputs 0, SHALL load instr_d<=imem_data, pc_d<=pc, valid_d<=1, pc<=pc+1.
REQ-015 pc increment SHALL wrap modulo 2^PC_W (all-ones -> 0).
REQ-016 In FLUSH, SHALL hold pc, force valid_d<=0, ignore stall_i and branch_taken_i; if fcnt=0 state<=RUN, else fcnt<=fcnt-1.
REQ-017 FLUSH SHALL therefore last exactly FLUSH_CYCLES cycles; first RUN cycle fetches branch_target_i.
REQ-018 resume_o SHALL be registered, 1 in exactly the first RUN cycle after FLUSH, 0 otherwise.
REQ-019 flush_busy SHALL be 1 iff state=FLUSH.
REQ-020 bubble_e SHALL be combinational: 1 iff (state=RUN and stall_i=1 and branch_taken_i=0) or state=FLUSH.
REQ-021 stall_cycles SHALL increment on each edge where REQ-013 applies, saturating at 16'hFFFF.
REQ-022 Consecutive stall cycles SHALL hold indefinitely with no fetch progress; stall release SHALL resume fetch at the held pc in the same edge (REQ-014).

Reset
REQ-023 reset=0 SHALL immediately, asynchronously set: pc=RESET_PC, state=RUN, fcnt=0, instr_d=0, pc_d=0, valid_d=0, resume_o=0, stall_cycles=0.
REQ-024 Reset assertion mid-FLUSH or mid-stall SHALL abandon the operation; after release, first edge fetches RESET_PC.

Verification
REQ-025 Reset release, inputs 0, imem_data=addr+16'h100 -> edges 1..3: pc_d=0,1,2, instr_d=16'h100,16'h101,16'h102, valid_d=1.
REQ-026 stall_i=1 for 3 cycles at pc=5 -> pc_d/instr_d frozen, bubble_e=1 for 3 cycles, stall_cycles=3, fetch resumes at 5.
REQ-027 branch_taken_i=1, target=16'h0040, same cycle stall_i=1 -> valid_d=0 and flush_busy=1 for 2 cycles, stall_cycles unchanged, resume_o pulse, next pc_d=16'h0040.
REQ-028 pc=16'hFFFF, no stall -> pc_d=16'hFFFF then next pc_d=16'h0000.
REQ-029 reset=0 asserted in first FLUSH cycle -> outputs at reset values before next edge; after release, pc_d=RESET_PC, resume_o never pulses.
REQ-030 Force stall_cycles to 16'hFFFE, hold stall_i=1 3 cycles -> stall_cycles=16'hFFFF, no wrap.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, RAW-stall hold and
// branch-redirect flush with a fixed number of bubble cycles.
module fetch_ctrl #(
    parameter int PC_W         = 16,
    parameter int INSTR_W      = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int RESET_PC     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [PC_W-1:0]    branch_target_i,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr_d,
    output logic [PC_W-1:0]    pc_d,
    output logic               valid_d,
    output logic               bubble_e,
    output logic               flush_busy,
    output logic               resume_o,
    output logic [15:0]        stall_cycles
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);
    localparam logic [3:0]      FC_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t              state, state_n;
    logic [3:0]          fcnt, fcnt_n;
    logic [PC_W-1:0]     pc, pc_n;
    logic [INSTR_W-1:0]  instr_n;
    logic [PC_W-1:0]     pc_d_n;
    logic                valid_n;
    logic                resume_n;
    logic [15:0]         stall_n;
    logic                hold;

    // A RAW hold only counts when no redirect is pending this cycle
    assign hold       = (state == RUN) && stall_i && !branch_taken_i;
    assign imem_addr  = pc;
    assign flush_busy = (state == FLUSH);
    assign bubble_e   = hold || (state == FLUSH);

    // Next-state and next-register computation for the fetch FSM
    always_comb begin
        state_n  = state;
        fcnt_n   = fcnt;
        pc_n     = pc;
        instr_n  = instr_d;
        pc_d_n   = pc_d;
        valid_n  = valid_d;
        resume_n = 1'b0;
        stall_n  = stall_cycles;
        unique case (state)
            RUN: begin
                if (branch_taken_i) begin
                    pc_n    = branch_target_i;
                    valid_n = 1'b0;
                    fcnt_n  = FC_LOAD;
                    state_n = FLUSH;
                end else if (stall_i) begin
                    if (stall_cycles != 16'hFFFF) begin
                        stall_n = stall_cycles + 16'd1;
                    end
                end else begin
                    instr_n = imem_data;
                    pc_d_n  = pc;
                    valid_n = 1'b1;
                    pc_n    = pc + PC_W'(1);
                end
            end
            FLUSH: begin
                valid_n = 1'b0;
                if (fcnt == 4'd0) begin
                    state_n  = RUN;
                    resume_n = 1'b1;
                end else begin
                    fcnt_n = fcnt - 4'd1;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    // State and pipeline registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            fcnt         <= 4'd0;
            pc           <= PC_RST;
            instr_d      <= '0;
            pc_d         <= '0;
            valid_d      <= 1'b0;
            resume_o     <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            state        <= state_n;
            fcnt         <= fcnt_n;
            pc           <= pc_n;
            instr_d      <= instr_n;
            pc_d         <= pc_d_n;
            valid_d      <= valid_n;
            resume_o     <= resume_n;
            stall_cycles <= stall_n;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a cycle-level reference model pushes
// the expected per-cycle outputs, a negedge monitor pops and compares.
module tb_fetch_ctrl;

    localparam int FC  = 2;
    localparam int RPC = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        branch_taken_i;
    logic [15:0] branch_target_i;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instr_d;
    logic [15:0] pc_d;
    logic        valid_d;
    logic        bubble_e;
    logic        flush_busy;
    logic        resume_o;
    logic [15:0] stall_cycles;

    fetch_ctrl #(
        .PC_W(16), .INSTR_W(16), .FLUSH_CYCLES(FC), .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall_i(stall_i),
        .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .instr_d(instr_d),
        .pc_d(pc_d),
        .valid_d(valid_d),
        .bubble_e(bubble_e),
        .flush_busy(flush_busy),
        .resume_o(resume_o),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Instruction memory: word at address a holds a + 0x100
    assign imem_data = imem_addr + 16'h0100;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pcd;
        logic        valid;
        logic        bubble;
        logic        busy;
        logic        resume;
        logic [15:0] stalls;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;

    int          m_pc;
    int          m_left;
    int          m_instr;
    int          m_pcd;
    bit          m_valid;
    bit          m_resume;
    int          m_stalls;
    bit          m_rst_held;
    bit          p_st;
    bit          p_br;
    int          p_tgt;

    task automatic model_reset();
        m_pc     = RPC;
        m_left   = 0;
        m_instr  = 0;
        m_pcd    = 0;
        m_valid  = 0;
        m_resume = 0;
        m_stalls = 0;
    endtask

    task automatic model_edge();
        if (m_left > 0) begin
            m_valid  = 0;
            m_left   = m_left - 1;
            m_resume = (m_left == 0);
        end else begin
            m_resume = 0;
            if (p_br) begin
                m_pc    = p_tgt;
                m_valid = 0;
                m_left  = FC;
            end else if (p_st) begin
                if (m_stalls < 65535) m_stalls = m_stalls + 1;
            end else begin
                m_pcd   = m_pc;
                m_instr = (m_pc + 256) % 65536;
                m_valid = 1;
                m_pc    = (m_pc + 1) % 65536;
            end
        end
    endtask

    task automatic cycle(input bit rn, input bit st, input bit br,
                         input logic [15:0] tgt);
        exp_t e;
        @(posedge clk);
        #1;
        if (!m_rst_held) model_edge();
        reset           = rn;
        stall_i         = st;
        branch_taken_i  = br;
        branch_target_i = tgt;
        if (!rn) model_reset();
        p_st       = st;
        p_br       = br;
        p_tgt      = int'(tgt);
        m_rst_held = !rn;
        e.addr   = 16'(m_pc);
        e.instr  = 16'(m_instr);
        e.pcd    = 16'(m_pcd);
        e.valid  = m_valid;
        e.busy   = (m_left > 0);
        e.bubble = (m_left > 0) || (st && !br);
        e.resume = m_resume;
        e.stalls = 16'(m_stalls);
        q.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cyc++;
                checks++;
                if (imem_addr === e.addr && instr_d === e.instr &&
                    pc_d === e.pcd && valid_d === e.valid &&
                    bubble_e === e.bubble && flush_busy === e.busy &&
                    resume_o === e.resume && stall_cycles === e.stalls) begin
                    passed++;
                end else begin
                    $display("FAIL cyc%0d got a=%h i=%h p=%h v=%b b=%b f=%b r=%b s=%h exp a=%h i=%h p=%h v=%b b=%b f=%b r=%b s=%h",
                        cyc, imem_addr, instr_d, pc_d, valid_d, bubble_e,
                        flush_busy, resume_o, stall_cycles, e.addr, e.instr,
                        e.pcd, e.valid, e.bubble, e.busy, e.resume, e.stalls);
                end
            end
        end
    end

    initial begin
        int guard;
        reset           = 1'b1;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 16'h0;
        m_rst_held      = 1'b1;
        p_st            = 0;
        p_br            = 0;
        p_tgt           = 0;
        model_reset();
        #1 reset = 1'b0;

        cycle(0, 0, 0, 16'h0);
        cycle(0, 0, 0, 16'h0);
        repeat (4) cycle(1, 0, 0, 16'h0);

        guard = 0;
        while (m_pc != 5 && guard < 20) begin
            cycle(1, 0, 0, 16'h0);
            guard++;
        end
        repeat (3) cycle(1, 1, 0, 16'h0);
        repeat (3) cycle(1, 0, 0, 16'h0);

        cycle(1, 1, 1, 16'h0040);
        repeat (5) cycle(1, 0, 0, 16'h0);

        cycle(1, 0, 1, 16'hFFFE);
        repeat (6) cycle(1, 0, 0, 16'h0);

        cycle(1, 0, 1, 16'h1234);
        cycle(0, 0, 0, 16'h0);
        cycle(0, 1, 1, 16'h5555);
        repeat (5) cycle(1, 0, 0, 16'h0);

        repeat (3000) begin
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0,
                  16'($urandom));
        end

        cycle(0, 0, 0, 16'h0);
        cycle(1, 0, 0, 16'h0);
        repeat (65540) cycle(1, 1, 0, 16'h0);
        repeat (3) cycle(1, 0, 0, 16'h0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL drain got %0d pending, need 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
